// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset and lock supervisor; loss counter enabled by PLL_RST_CTRL_LOSS_CNT_EN
module pll_reset_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RELOCK_TIMEOUT = 65535,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic [1:0] state,
  output logic [7:0] loss_cnt
);
  localparam int RW = $clog2(PLL_RST_CYCLES);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(RELOCK_TIMEOUT);
  localparam int MW = (RW > SW) ? ((RW > TW) ? RW : TW) : ((SW > TW) ? SW : TW);
  localparam int CW = (MW < 1) ? 1 : MW;
  localparam logic [CW-1:0] R_END = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] S_END = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] T_END = CW'(RELOCK_TIMEOUT - 1);
  typedef enum logic [1:0] {S_PLLRST = 2'd0, S_WAIT = 2'd1, S_STABLE = 2'd2, S_RUN = 2'd3} state_t;
  state_t cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic locked_s;
  assign locked_s  = sync[SYNC_STAGES-1];
  assign state     = cur;
  assign pll_ready = sys_rst_n;
  // bring the asynchronous lock indication into the refclk domain
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], locked};
  // one shared counter serves every state since it is cleared on each state entry
  always_comb begin
    nxt = cur;
    case (cur)
      S_PLLRST: nxt = (cnt == R_END) ? S_WAIT : S_PLLRST;
      S_WAIT:   nxt = locked_s ? S_STABLE : (cnt == T_END) ? S_PLLRST : S_WAIT;
      S_STABLE: nxt = !locked_s ? S_WAIT : (cnt == S_END) ? S_RUN : S_STABLE;
      default:  nxt = locked_s ? S_RUN : S_WAIT;
    endcase
    if (soft_rst_req) nxt = S_PLLRST;
    cnt_nxt = (soft_rst_req || nxt != cur || cur == S_RUN) ? '0 : cnt + CW'(1);
  end
  // state, counter and registered reset outputs derived from the next state
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      cur       <= S_PLLRST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
    end else begin
      cur       <= nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= (nxt == S_PLLRST);
      sys_rst_n <= (nxt == S_RUN);
    end
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  // saturating count of lock losses seen while running; soft requests do not clear it
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) loss_cnt <= 8'd0;
    else if (cur == S_RUN && !locked_s && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 8'd1;
`else
  assign loss_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: directed and randomized checks of pll_reset_ctrl against a behavioural model
module tb_pll_reset_ctrl;
  localparam int SS = 2;
  localparam int SC = 8;
  localparam int RT = 32;
  localparam int PR = 4;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic refclk = 1'b0;
  logic rst_n, locked, soft_rst_req;
  logic pll_rst, sys_rst_n, pll_ready;
  logic [1:0] state;
  logic [7:0] loss_cnt;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int m_mode, m_age, m_loss;
  bit q[$];
  pll_reset_ctrl #(
    .SYNC_STAGES(SS),
    .STABLE_CYCLES(SC),
    .RELOCK_TIMEOUT(RT),
    .PLL_RST_CYCLES(PR)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .locked(locked),
    .soft_rst_req(soft_rst_req),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .pll_ready(pll_ready),
    .state(state),
    .loss_cnt(loss_cnt)
  );
  always #5 refclk = ~refclk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0;
    m_age  = 0;
    m_loss = 0;
    q.delete();
    repeat (SS) q.push_back(1'b0);
  endtask
  // mode: 0 pulse, 1 waiting, 2 qualifying, 3 running; m_age = edges already spent in mode
  task automatic model_step();
    bit ls;
    int n, nm;
    if (!rst_n) return;
    ls = q.pop_front();
    q.push_back(locked);
    if (CNT_EN && m_mode == 3 && !ls && m_loss < 255) m_loss++;
    n  = m_age + 1;
    nm = m_mode;
    if (soft_rst_req) nm = 0;
    else if (m_mode == 0) nm = (n == PR) ? 1 : 0;
    else if (m_mode == 1) nm = ls ? 2 : ((n == RT) ? 0 : 1);
    else if (m_mode == 2) nm = !ls ? 1 : ((n == SC) ? 3 : 2);
    else nm = ls ? 3 : 1;
    m_age  = (soft_rst_req || nm != m_mode) ? 0 : n;
    m_mode = nm;
  endtask
  task automatic cyc(input logic l, input logic s);
    locked       = l;
    soft_rst_req = s;
    @(posedge refclk);
    model_step();
    #2;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask
  always @(negedge refclk)
    if (chk_en) begin
      chk("state", state, m_mode);
      chk("pll_rst", pll_rst, m_mode == 0);
      chk("sys_rst_n", sys_rst_n, m_mode == 3);
      chk("pll_ready", pll_ready, m_mode == 3);
      chk("loss_cnt", loss_cnt, m_loss);
    end
  initial begin
    rst_n = 1'b1;
    locked = 1'b0;
    soft_rst_req = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_state", state, 0);
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cyc(k >= 10, 1'b0);
      if (k <= 3) chk("pwr_pll_rst_hi", pll_rst, 1);
      if (k == 4) begin
        chk("pwr_pll_rst_lo", pll_rst, 0);
        chk("pwr_wait", state, 1);
      end
      if (k == 19) chk("pwr_sys_pre", sys_rst_n, 0);
      if (k == 20) begin
        chk("pwr_sys_rise", sys_rst_n, 1);
        chk("pwr_run", state, 3);
      end
    end
    repeat (3) cyc(1'b1, 1'b0);
    for (int k = 0; k <= 13; k++) begin
      cyc(k >= 3, 1'b0);
      if (k == 1) chk("loss_sys_hold", sys_rst_n, 1);
      if (k == 2) begin
        chk("loss_sys_fall", sys_rst_n, 0);
        chk("loss_cnt_1", loss_cnt, CNT_EN ? 1 : 0);
      end
      if (k == 12) chk("loss_sys_pre", sys_rst_n, 0);
      if (k == 13) chk("loss_sys_rise", sys_rst_n, 1);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("soft_state", state, 0);
    chk("soft_pll_rst", pll_rst, 1);
    chk("soft_sys_rst_n", sys_rst_n, 0);
    chk("soft_loss_cnt", loss_cnt, CNT_EN ? 2 : 0);
    do_reset();
    for (int k = 1; k <= 72; k++) begin
      cyc(1'b0, 1'b0);
      if (k == 35) chk("to_wait_end", state, 1);
      if (k == 36) begin
        chk("to_repulse", state, 0);
        chk("to_pll_rst", pll_rst, 1);
      end
      if (k == 40) chk("to_pulse_end", state, 1);
      if (k == 72) chk("to_second", state, 0);
    end
    do_reset();
    repeat (4) cyc(1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      repeat (5) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    for (int k = 0; k <= 10; k++) begin
      cyc(1'b1, 1'b0);
      if (k == 9) chk("glitch_sys_pre", sys_rst_n, 0);
      if (k == 10) chk("glitch_sys_rise", sys_rst_n, 1);
    end
    repeat (260) begin
      cyc(1'b0, 1'b0);
      repeat (12) cyc(1'b1, 1'b0);
    end
    chk("sat_loss_cnt", loss_cnt, CNT_EN ? 255 : 0);
    repeat (300) begin
      logic v;
      int len;
      v = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) cyc(v, $urandom_range(0, 63) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
      end
    end
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
